// File: rtl/alu_cmp_arbiter.sv
// Two-requester front end for one shared 32-bit compare unit: round-robin grant,
// IDLE/EXEC/HOLD sequencing and a held mask/flag result over valid/ready.
module alu_cmp_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_out,
  output logic             res_flag,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             ptr_q, ptr_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [WIDTH-1:0] res_out_q, res_out_d;
  logic             res_flag_q, res_flag_d;
  logic             gnt0_s, gnt1_s, cmp_s;

  // Round-robin grant; ptr names the requester that wins a tie.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0_s = ~ptr_q;
        gnt1_s = ptr_q;
      end else begin
        gnt0_s = req0_valid;
        gnt1_s = req1_valid;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Compare on the latched operands only.
  always_comb begin
    cmp_s = 1'b0;
    case (op_q)
      2'b00:   cmp_s = (a_q >= b_q);
      2'b01:   cmp_s = (a_q < b_q);
      2'b10:   cmp_s = (a_q == b_q);
      2'b11:   cmp_s = ($signed(a_q) >= $signed(b_q));
      default: cmp_s = 1'b0;
    endcase
  end

  // Next-state and datapath update for the accept/execute/hold sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_out_d   = res_out_q;
    res_flag_d  = res_flag_q;
    case (state_q)
      IDLE: begin
        if (gnt0_s) begin
          op_d     = req0_op;
          a_d      = req0_a;
          b_d      = req0_b;
          res_id_d = 1'b0;
          state_d  = EXEC;
        end else if (gnt1_s) begin
          op_d     = req1_op;
          a_d      = req1_a;
          b_d      = req1_b;
          res_id_d = 1'b1;
          state_d  = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        res_out_d   = cmp_s ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        res_flag_d  = ~cmp_s;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        // The requester just served drops to lower priority.
        if (res_ready) begin
          res_valid_d = 1'b0;
          ptr_d       = ~res_id_q;
          state_d     = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      op_q        <= 2'b00;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_out_q   <= {WIDTH{1'b0}};
      res_flag_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_out_q   <= res_out_d;
      res_flag_q  <= res_flag_d;
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_out    = res_out_q;
  assign res_flag   = res_flag_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu_cmp_arbiter.md
# alu_cmp_arbiter

Shares a single 32-bit compare unit (unsigned GE/LT, equality, signed GE) between two requesters on the ALU side of the design. A round-robin arbiter grants one request at a time. A three-state controller sequences each grant through accept, execute and hold phases. The result is returned as the ALU's all-ones/all-zeros mask plus a zero flag, tagged with the requester id, over a valid/ready handshake.

## Interface
- WIDTH, 32, operand and mask width
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 transfer accepted this cycle
- req0_op  in  2  00 UGE, 01 ULT, 10 EQ, 11 SGE
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- res_valid  out  1  result held and valid
- res_ready  in  1  consumer accepts result
- res_id  out  1  requester that issued the result
- res_out  out  WIDTH  all ones if the compare is true, else all zeros
- res_flag  out  1  1 when res_out == 0, else 0
- busy  out  1  state != IDLE

## Operation
- State machine: IDLE, EXEC, HOLD.
- IDLE, grant (combinational):
  - If both requesters are valid, grant the one selected by priority pointer `ptr`.
  - If only one is valid, grant that one.
  - `reqK_ready` = 1 only for the granted requester, and only in IDLE. Both are 0 when no request is valid.
- Transfer happens when `reqK_valid & reqK_ready`. On that edge:
  - latch op, a, b into internal registers;
  - set `res_id` = K;
  - go to EXEC.
- EXEC: compute from the latched operands.
  - UGE: a >= b, unsigned.
  - ULT: a < b, unsigned.
  - EQ: a == b.
  - SGE: a >= b, two's complement.
  - Register `res_out`, set `res_flag` = (res_out == 0) and `res_valid` = 1, then go to HOLD.
  - Requester inputs are ignored in EXEC and HOLD. Changes to req*_a/b after transfer must not affect the result.
- HOLD: `res_valid`, `res_out`, `res_flag` and `res_id` stay stable until `res_ready` = 1.
  - On the edge where `res_valid & res_ready`: clear `res_valid`, set `ptr` = ~res_id, go to IDLE.
- `ptr` changes only on result acceptance, so the last-served requester gets the lower priority.
- `res_out`, `res_flag` and `res_id` keep their last values in IDLE. Only `res_valid` qualifies them.
- Invariant: `res_flag` == (res_out == 0) in every cycle.

## Timing
- Reset values: state IDLE, `res_valid` 0, `res_out` 0, `res_flag` 1, `res_id` 0, `ptr` 0 (requester 0 first), `busy` 0, both `reqK_ready` 0.
- Reset asserted in any state returns to IDLE on the next edge. Any in-flight operation and held result are discarded and no handshake completes in that cycle.
- Latency: transfer at edge T gives `res_valid` = 1 after edge T+1.
- Minimum issue interval is 3 cycles: transfer, EXEC, and acceptance in the first HOLD cycle. The next transfer can occur at edge T+3.
- `res_ready` held high has no effect outside HOLD.
- A requester that deasserts valid before being granted loses nothing. No request is stored unless a transfer occurs.
- Both requesters valid continuously: grants alternate 0,1,0,1…
- Equal operands:
  - UGE → all ones, flag 0.
  - ULT → zeros, flag 1.
  - EQ → ones.
  - SGE → ones.
- Sign boundary, a=32'h8000_0000, b=32'h0000_0001:
  - UGE → ones.
  - SGE → zeros, flag 1.

## Test plan
- Reset then idle: after `rst` is held 2 cycles, check `res_valid`=0, `res_out`=0, `res_flag`=1 and `busy`=0. With no valids, both readies stay 0.
- Single UGE from requester 0 (a=5, b=3): `req0_ready`=1 in the transfer cycle; one cycle later `res_valid`=1, `res_out`=32'hFFFF_FFFF, `res_flag`=0, `res_id`=0.
- Contention: both valid continuously, `res_ready`=1. Grants go 0,1,0,1; `res_id` alternates; one result every 3 cycles.
- Backpressure: `res_ready`=0 for 5 cycles during HOLD. Result stays stable, both readies stay 0, no new transfer occurs. After `res_ready`=1, IDLE follows next cycle.
- Op coverage with a=32'h8000_0000, b=1:
  - UGE → ones.
  - ULT → zeros, flag 1.
  - EQ → zeros.
  - SGE → zeros.
  - Repeat with a=b=7 to get ones, zeros, ones, ones.
- Mid-operation reset: assert `rst` in EXEC and, in a separate run, in HOLD. Next cycle shows state IDLE, `res_valid`=0, `ptr`=0, and the pending result is never delivered.
